// File: rtl/register_bank.sv
// register_bank: 32 x 32-bit MIPS general-purpose register file.
// Two combinational read ports, one clocked write port, r0 hardwired to zero.
// Optional write-through bypass lets a read see this cycle's write data.
module register_bank #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr1,
    output logic [DATA_W-1:0] rd_data1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data2,
    input  logic [ADDR_W-1:0] rw_addr,
    input  logic [DATA_W-1:0] rw_data,
    input  logic              rw_en
);

    localparam int DEPTH = 2 ** ADDR_W;

    // Name kept as Reg so benches can preload and peek by hierarchy.
    logic [DATA_W-1:0] Reg [0:DEPTH-1];

    logic wr_live;
    logic hit1;
    logic hit2;

    // r0 writes are dropped here rather than masked on read only, so the array stays clean.
    assign wr_live = rw_en && (rw_addr != '0);
    assign hit1    = (BYPASS != 0) && wr_live && (rd_addr1 == rw_addr);
    assign hit2    = (BYPASS != 0) && wr_live && (rd_addr2 == rw_addr);

    // Storage: async clear of every entry, otherwise a single write per edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                Reg[i] <= '0;
            end
        end else if (wr_live) begin
            Reg[rw_addr] <= rw_data;
        end
    end

    // Read port 1: zero while in reset or addressing r0 (even if r0 was forced), else bypass or array.
    always_comb begin
        rd_data1 = '0;
        if (!rst && (rd_addr1 != '0)) begin
            rd_data1 = hit1 ? rw_data : Reg[rd_addr1];
        end
    end

    // Read port 2: same rules as port 1, evaluated independently.
    always_comb begin
        rd_data2 = '0;
        if (!rst && (rd_addr2 != '0)) begin
            rd_data2 = hit2 ? rw_data : Reg[rd_addr2];
        end
    end

endmodule

// File: tb/tb_register_bank.sv
// Bench for register_bank: directed vectors, an array model of the register
// file checked on every falling edge, and literal spot checks.
module tb_register_bank;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  rd_addr1 = '0;
    logic [31:0] rd_data1;
    logic [4:0]  rd_addr2 = '0;
    logic [31:0] rd_data2;
    logic [4:0]  rw_addr = '0;
    logic [31:0] rw_data = '0;
    logic        rw_en = 1'b0;

    int n_cmp = 0;
    int n_err = 0;
    bit cmp_on = 1'b0;

    logic [31:0] mdl [0:31];

    register_bank #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) dut (
        .clk(clk), .rst(rst),
        .rd_addr1(rd_addr1), .rd_data1(rd_data1),
        .rd_addr2(rd_addr2), .rd_data2(rd_data2),
        .rw_addr(rw_addr), .rw_data(rw_data), .rw_en(rw_en)
    );

    always #5 clk = ~clk;

    initial for (int i = 0; i < 32; i++) mdl[i] = '0;

    // Model: clear on reset, take enabled non-zero writes on the rising edge.
    always @(posedge rst) for (int i = 0; i < 32; i++) mdl[i] = '0;
    always @(posedge clk) if (!rst && rw_en && rw_addr != 5'd0) mdl[rw_addr] = rw_data;

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (rst) return 32'd0;
        if (a == 5'd0) return 32'd0;
        if (rw_en && rw_addr != 5'd0 && a == rw_addr) return rw_data;
        return mdl[a];
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    // Continuous compare of both read ports against the model.
    always @(negedge clk) begin
        if (cmp_on) begin
            check("cmp_rd1", rd_data1, exp_rd(rd_addr1));
            check("cmp_rd2", rd_data2, exp_rd(rd_addr2));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [4:0]  tbl_a [0:3];
    logic [31:0] tbl_d [0:3];

    initial begin
        // Reset with no clock edge yet (first rising edge is at t=5).
        #1;
        dut.Reg[2] = 32'd77;
        #1 rst = 1'b1;
        rd_addr1 = 5'd2;
        rd_addr2 = 5'd3;
        #1;
        check("rst_peek_r2", dut.Reg[2], 32'd0);
        check("rst_rd1", rd_data1, 32'd0);
        check("rst_rd2", rd_data2, 32'd0);
        #1 rst = 1'b0;
        tick();
        cmp_on = 1'b1;

        // Preloaded read, zero latency on address change.
        dut.Reg[1] = 32'd2; mdl[1] = 32'd2;
        dut.Reg[2] = 32'd3; mdl[2] = 32'd3;
        dut.Reg[3] = 32'd4; mdl[3] = 32'd4;
        rd_addr1 = 5'd0;
        rd_addr2 = 5'd1;
        #1;
        check("pre_rd1_a0", rd_data1, 32'd0);
        check("pre_rd2_a1", rd_data2, 32'd2);
        rd_addr1 = 5'd2;
        rd_addr2 = 5'd3;
        #1;
        check("pre_rd1_a2", rd_data1, 32'd3);
        check("pre_rd2_a3", rd_data2, 32'd4);
        tick();

        // Successive writes to r31 with bypass visible before each edge.
        rd_addr1 = 5'd31;
        rw_addr  = 5'd31;
        rw_en    = 1'b1;
        for (int v = 7; v <= 9; v++) begin
            rw_data = 32'(v);
            #1;
            check("r31_bypass", rd_data1, 32'(v));
            tick();
            check("r31_stored", dut.Reg[31], 32'(v));
        end
        rw_en = 1'b0;
        rw_data = 32'd0;
        #1;
        check("r31_after", rd_data1, 32'd9);
        tick();

        // Zero register: write discarded, forced content masked.
        rd_addr1 = 5'd0;
        rw_addr  = 5'd0;
        rw_data  = 32'hFFFF_FFFF;
        rw_en    = 1'b1;
        #1;
        check("r0_bypass", rd_data1, 32'd0);
        tick();
        rw_en = 1'b0;
        check("r0_rd", rd_data1, 32'd0);
        check("r0_peek", dut.Reg[0], 32'd0);
        dut.Reg[0] = 32'd5;
        #1;
        check("r0_forced", rd_data1, 32'd0);
        tick();

        // Write enable low leaves register untouched, and no bypass.
        rw_addr = 5'd4; rw_data = 32'h11; rw_en = 1'b1;
        rd_addr2 = 5'd4;
        tick();
        rw_data = 32'hA5; rw_en = 1'b0;
        #1;
        check("en0_pre", rd_data2, 32'h11);
        tick();
        check("en0_post", rd_data2, 32'h11);

        // Port-2 bypass and cross-address independence.
        tbl_a[0] = 5'd7;  tbl_d[0] = 32'h0000_0701;
        tbl_a[1] = 5'd13; tbl_d[1] = 32'h1313_0000;
        tbl_a[2] = 5'd20; tbl_d[2] = 32'h8000_0001;
        tbl_a[3] = 5'd7;  tbl_d[3] = 32'h0BAD_F00D;
        for (int k = 0; k < 4; k++) begin
            rw_addr = tbl_a[k]; rw_data = tbl_d[k]; rw_en = 1'b1;
            rd_addr2 = tbl_a[k];
            rd_addr1 = 5'd3;
            #1;
            check("p2_bypass", rd_data2, tbl_d[k]);
            check("p1_other", rd_data1, 32'd4);
            tick();
        end
        rw_en = 1'b0;
        rd_addr1 = 5'd13;
        rd_addr2 = 5'd7;
        #1;
        check("tbl_r13", rd_data1, 32'h1313_0000);
        check("tbl_r7", rd_data2, 32'h0BAD_F00D);
        tick();

        // Reset between edges clears immediately.
        rw_addr = 5'd5; rw_data = 32'h1234; rw_en = 1'b1;
        tick();
        rw_en = 1'b0;
        rd_addr1 = 5'd5;
        #1;
        check("r5_written", rd_data1, 32'h1234);
        rst = 1'b1;
        #1;
        check("r5_rst_rd", rd_data1, 32'd0);
        check("r5_rst_peek", dut.Reg[5], 32'd0);
        check("r31_rst_peek", dut.Reg[31], 32'd0);
        rst = 1'b0;
        tick();

        // Reset held across a write edge: reset wins.
        rw_addr = 5'd6; rw_data = 32'h66; rw_en = 1'b1;
        rd_addr1 = 5'd6;
        rst = 1'b1;
        tick();
        check("r6_rst_peek", dut.Reg[6], 32'd0);
        rst = 1'b0;
        rw_en = 1'b0;
        #1;
        check("r6_rst_rd", rd_data1, 32'd0);
        tick();

        // Dual-port same address.
        rw_addr = 5'd10; rw_data = 32'hDEAD_BEEF; rw_en = 1'b1;
        tick();
        rw_en = 1'b0;
        rd_addr1 = 5'd10;
        rd_addr2 = 5'd10;
        #1;
        check("dual_rd1", rd_data1, 32'hDEAD_BEEF);
        check("dual_rd2", rd_data2, 32'hDEAD_BEEF);
        tick();
        tick();

        cmp_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/register_bank.md
Name: register_bank

Overview:
- 32 x 32-bit general-purpose register file for the mips32 datapath.
- Two asynchronous (combinational) read ports feed the ALU operand paths.
- One synchronous write port is driven from the writeback stage.
- Register 0 is hardwired to zero, per MIPS convention.

Parameters:
- DATA_W, 32, register and data-port width in bits.
- ADDR_W, 5, address width; depth = 2**ADDR_W = 32 registers.
- BYPASS, 1, when 1 a read of the register being written this cycle returns the new write data (write-through); when 0 it returns the stored value.

Ports:
- clk  input  1  system clock; writes occur on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- rd_addr1  input  5  read port 1 address.
- rd_data1  output  32  read port 1 data.
- rd_addr2  input  5  read port 2 address.
- rd_data2  output  32  read port 2 data.
- rw_addr  input  5  write address.
- rw_data  input  32  write data.
- rw_en  input  1  write enable, active-high.

Behaviour:
- Storage: internal array named Reg[0:31], each DATA_W bits wide. The name Reg is fixed so benches can preload and peek hierarchically (inst.Reg[n]).
- Reset: when rst=1, all 32 registers clear to 0 immediately, with no clock required. While rst is held, no writes occur, and both read ports output 0.
- Write: on posedge clk with rst=0 and rw_en=1, Reg[rw_addr] <= rw_data.
  - Writes to address 0 are discarded; Reg[0] stays 0.
  - rw_en=0 leaves all registers unchanged.
- Read: fully combinational, zero latency.
  - rd_dataN = Reg[rd_addrN], updating in the same delta as an address or content change.
  - Address 0 always reads 0, regardless of array contents, including any value forced by a bench.
- Bypass (BYPASS=1): if rw_en=1, rw_addr != 0 and rd_addrN == rw_addr, then rd_dataN = rw_data combinationally, before the edge. Each read port evaluates this independently.
- Both read ports may address the same register simultaneously; both return identical data.
- A write and a read of different addresses in the same cycle do not interact.
- Post-edge value: after the write edge, reads of the written address return the new value whether or not bypass is enabled.
- Reset mid-write: if rst asserts in the same cycle as a write, reset wins and the register reads 0.
- No X propagation: all 32 addresses are valid and there is no out-of-range case.
- Timing: writes visible at the next edge; reads available the same cycle.

Test Plan:
- Reset: assert rst with no clock edge -> all Reg[n]=0; rd_addr1=2 and rd_addr2=3 give rd_data1=0, rd_data2=0.
- Preloaded read: hierarchically set Reg[1]=2, Reg[2]=3, Reg[3]=4.
  - rd_addr1=0, rd_addr2=1 -> rd_data1=0, rd_data2=2.
  - After 5 time units, change to rd_addr1=2, rd_addr2=3 -> rd_data1=3, rd_data2=4 with zero latency.
- Successive writes to r31: rw_addr=31, rw_en=1, writing 7, 8, 9 on three consecutive rising edges -> Reg[31] reads 7, then 8, then 9 after each edge. With rd_addr1=31 and BYPASS=1, rd_data1 shows each value before its edge.
- Zero register:
  - rw_addr=0, rw_data=0xFFFFFFFF, rw_en=1, clock -> rd_data1 at address 0 = 0.
  - Force Reg[0]=5 hierarchically -> read at address 0 still returns 0.
- Write enable and reset priority:
  - rw_en=0, rw_addr=4, rw_data=0xA5, clock -> Reg[4] unchanged.
  - Write 0x1234 to reg 5, then assert rst between edges -> rd_data at address 5 drops to 0 immediately.
- Dual-port same address: rd_addr1=rd_addr2=10 after writing 0xDEADBEEF -> both outputs read 0xDEADBEEF.
